// File: rtl/cms_config_sequencer_if.sv
// Host-side config push channel of the CMS config sequencer.
// The host (master) offers (addr,data) pairs with valid/ready; the sequencer (slave) accepts them.
interface cms_config_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [DATA_WIDTH-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/cms_config_sequencer.sv
// CMS config sequencer: queues (addr,data) config pairs from the host and, on commit,
// holds the CMS disabled, replays the queue as single-cycle write pulses, then re-enables it.
module cms_config_sequencer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  cms_config_sequencer_if.slave    cfg,
  input  logic                     commit,
  input  logic                     abort,
  output logic [ADDR_WIDTH-1:0]    ctrl_addr,
  output logic [DATA_WIDTH-1:0]    ctrl_wdata,
  output logic                     ctrl_write_enable,
  output logic                     cms_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW:0]   FULL_LEVEL  = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WRITE,
    GAP,
    FINISH
  } state_t;

  state_t                           state;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] queue_mem [DEPTH];
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr;
  logic [CW-1:0]                    cnt;
  logic                             full;
  logic                             push;
  logic                             start_write;

  assign full          = (pending == FULL_LEVEL);
  assign cfg.cfg_ready = !full && (state == IDLE);
  // An abort in the same cycle flushes the queue, so a coincident push is dropped.
  assign push          = cfg.cfg_valid && cfg.cfg_ready && !abort;
  assign busy          = (state != IDLE);

  // A write pulse is launched when the settle or gap interval expires with work left.
  // The SETTLE path needs no pending check: SETTLE is only entered with a non-empty queue.
  assign start_write = !abort && (cnt == '0) &&
                       ((state == SETTLE) || ((state == GAP) && (pending != '0)));

  // Queue storage, written on every accepted push.
  // NOTE: the storage array is deliberately not reset; an entry is only read after it has
  // been written and counted in pending, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= {cfg.cfg_addr, cfg.cfg_data};
  end

  // Replay FSM with queue pointers, occupancy and all registered CMS-facing outputs.
  // NOTE: every register here uses non-blocking assignment so all right-hand sides see the
  // pre-edge values; a blocking assignment would let later statements see the updated value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      pending           <= '0;
      cnt               <= '0;
      ctrl_addr         <= '0;
      ctrl_wdata        <= '0;
      ctrl_write_enable <= 1'b0;
      cms_en            <= 1'b0;
      done              <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless re-launched below.
      ctrl_write_enable <= 1'b0;
      done              <= 1'b0;

      if (abort) begin
        // Flush and return to IDLE; cms_en is left as it is.
        state   <= IDLE;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        pending <= '0;
        cnt     <= '0;
      end else begin
        // Pushes only happen in IDLE and pops never do, so they cannot collide on pending.
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          pending <= pending + 1'b1;
        end

        unique case (state)
          IDLE: begin
            if (commit) begin
              if (pending != '0) begin
                state  <= SETTLE;
                cms_en <= 1'b0;
                cnt    <= SETTLE_LOAD;
              end else begin
                state  <= FINISH;
                done   <= 1'b1;
                cms_en <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          WRITE: begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end
          GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (pending == '0) begin
              state  <= FINISH;
              done   <= 1'b1;
              cms_en <= 1'b1;
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase

        if (start_write) begin
          state                   <= WRITE;
          ctrl_write_enable       <= 1'b1;
          {ctrl_addr, ctrl_wdata} <= queue_mem[rd_ptr];
          rd_ptr                  <= rd_ptr + 1'b1;
          pending                 <= pending - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cms_config_sequencer.sv
// Bench for cms_config_sequencer: directed scenarios plus randomized replays checked
// against a queue model with arithmetic pulse/done timing.
module tb_cms_config_sequencer;
  localparam int AW     = 8;
  localparam int DW     = 64;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int GAP    = 1;
  localparam int PW     = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          commit;
  logic          abort;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_write_enable;
  logic          cms_en;
  logic          busy;
  logic          done;
  logic [PW:0]   pending;

  cms_config_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cfg_if ();

  cms_config_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if.slave), .commit(commit), .abort(abort),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .cms_en(cms_en), .busy(busy), .done(done), .pending(pending)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the queue contents in push order.
  entry_t model_q[$];

  // Observations of one replay window, indexed by cycle offset from the commit edge.
  int          obs_pulse_rel[$];
  entry_t      obs_pulse[$];
  int          obs_done_rel[$];
  logic        obs_en[64];
  logic        obs_busy[64];
  logic [PW:0] obs_pending[64];
  int          obs_abort_rel;
  int          obs_we_b2b;

  function automatic int exp_pulse_rel(input int k);
    return 1 + SETTLE + k * (GAP + 1);
  endfunction

  function automatic int exp_done_rel(input int n);
    return (n == 0) ? 1 : exp_pulse_rel(n - 1) + GAP + 1;
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    e.addr = AW'($urandom);
    e.data = {$urandom, $urandom};
    return e;
  endfunction

  // One push attempt; returns the observed ready, the model accepts while not full.
  task automatic push_entry(input entry_t e, output bit acc);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = e.addr;
    cfg_if.cfg_data  = e.data;
    acc = cfg_if.cfg_ready;
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(e);
  endtask

  // Commit, then record outputs for 'budget' cycles. Optionally re-pulse commit at
  // commit_rel, abort right after the abort_after-th pulse, and push while busy.
  task automatic watch(input int budget, input int commit_rel, input int abort_after,
                       input bit push_noise);
    logic prev_we;
    int   npulse;
    prev_we = 1'b0;
    npulse  = 0;
    obs_pulse_rel.delete();
    obs_pulse.delete();
    obs_done_rel.delete();
    obs_abort_rel = -1;
    obs_we_b2b    = 0;
    @(negedge clk);
    commit = 1'b1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      commit = (rel == commit_rel);
      abort  = 1'b0;
      cfg_if.cfg_valid = push_noise && busy && ($urandom_range(0, 1) == 1);
      cfg_if.cfg_addr  = AW'($urandom);
      if (ctrl_write_enable) begin
        if (prev_we) obs_we_b2b++;
        obs_pulse_rel.push_back(rel);
        obs_pulse.push_back({ctrl_addr, ctrl_wdata});
        npulse++;
        if (abort_after != 0 && npulse == abort_after) begin
          abort = 1'b1;
          obs_abort_rel = rel;
        end
      end
      prev_we = ctrl_write_enable;
      if (done) obs_done_rel.push_back(rel);
      if (rel < 64) begin
        obs_en[rel]      = cms_en;
        obs_busy[rel]    = busy;
        obs_pending[rel] = pending;
      end
    end
    commit = 1'b0;
    abort  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; commit = 1'b0; abort = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({ctrl_write_enable, cms_en, done, busy, cfg_if.cfg_ready} !== 5'b00001) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00001", {ctrl_write_enable, cms_en, done, busy, cfg_if.cfg_ready}); end
    tests_run++; if (ctrl_addr !== '0 || ctrl_wdata !== '0) begin tests_failed++; $display("FAIL reset_ctrl_bus: got %0h/%0h expected 0/0", ctrl_addr, ctrl_wdata); end
    tests_run++; if (pending !== '0) begin tests_failed++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic test_directed_replay();
    entry_t e[3];
    bit acc;
    int exp_rel[3] = '{3, 5, 7};
    e[0] = '{addr: 8'd0, data: 64'h1};
    e[1] = '{addr: 8'd2, data: 64'h8000_0008};
    e[2] = '{addr: 8'd3, data: 64'h8000_0040};
    for (int i = 0; i < 3; i++) push_entry(e[i], acc);
    tests_run++; if (pending !== 3) begin tests_failed++; $display("FAIL directed_pending: got %0d expected 3", pending); end
    watch(12, 0, 0, 1'b0);
    tests_run++; if (obs_pulse_rel.size() != 3) begin tests_failed++; $display("FAIL directed_pulse_count: got %0d expected 3", obs_pulse_rel.size()); end
    for (int i = 0; i < 3 && i < obs_pulse_rel.size(); i++) begin
      tests_run++; if (obs_pulse_rel[i] != exp_rel[i] || obs_pulse[i] !== e[i]) begin tests_failed++; $display("FAIL directed_pulse%0d: got cycle %0d %0h expected cycle %0d %0h", i, obs_pulse_rel[i], obs_pulse[i], exp_rel[i], e[i]); end
    end
    tests_run++; if (obs_done_rel.size() != 1 || obs_done_rel[0] != 9) begin tests_failed++; $display("FAIL directed_done: got %0d pulses first %0d expected 1 at 9", obs_done_rel.size(), (obs_done_rel.size() > 0) ? obs_done_rel[0] : -1); end
    for (int rel = 1; rel <= 9; rel++) begin
      tests_run++; if (obs_en[rel] !== (rel == 9)) begin tests_failed++; $display("FAIL directed_cms_en_c%0d: got %b expected %b", rel, obs_en[rel], rel == 9); end
    end
    tests_run++; if (obs_busy[10] !== 1'b0 || pending !== 0 || cfg_if.cfg_ready !== 1'b1 || obs_we_b2b != 0) begin tests_failed++; $display("FAIL directed_end: got busy %b pending %0d ready %b b2b %0d expected 0 0 1 0", obs_busy[10], pending, cfg_if.cfg_ready, obs_we_b2b); end
    model_q.delete();
  endtask

  task automatic test_full_queue();
    bit acc;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      push_entry(rand_entry(), acc);
      tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL full_accept%0d: got ready %b expected 1", i, acc); end
    end
    tests_run++; if (pending !== DEPTH || cfg_if.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL full_level: got pending %0d ready %b expected %0d 0", pending, cfg_if.cfg_ready, DEPTH); end
    push_entry(rand_entry(), acc);
    tests_run++; if (acc !== 1'b0 || pending !== DEPTH) begin tests_failed++; $display("FAIL full_refuse: got ready %b pending %0d expected 0 %0d", acc, pending, DEPTH); end
    n = model_q.size();
    watch(exp_done_rel(n) + 3, 0, 0, 1'b1);
    tests_run++; if (obs_pulse.size() != n) begin tests_failed++; $display("FAIL full_pulse_count: got %0d expected %0d", obs_pulse.size(), n); end
    for (int i = 0; i < n && i < obs_pulse.size(); i++) begin
      tests_run++; if (obs_pulse[i] !== model_q[i] || obs_pulse_rel[i] != exp_pulse_rel(i)) begin tests_failed++; $display("FAIL full_pulse%0d: got cycle %0d %0h expected cycle %0d %0h", i, obs_pulse_rel[i], obs_pulse[i], exp_pulse_rel(i), model_q[i]); end
    end
    tests_run++; if (pending !== 0 || cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL full_drained: got pending %0d ready %b expected 0 1", pending, cfg_if.cfg_ready); end
    model_q.delete();
  endtask

  task automatic test_empty_commit();
    watch(4, 0, 0, 1'b0);
    tests_run++; if (obs_pulse.size() != 0) begin tests_failed++; $display("FAIL empty_pulses: got %0d expected 0", obs_pulse.size()); end
    tests_run++; if (obs_done_rel.size() != 1 || obs_done_rel[0] != 1) begin tests_failed++; $display("FAIL empty_done: got %0d pulses first %0d expected 1 at 1", obs_done_rel.size(), (obs_done_rel.size() > 0) ? obs_done_rel[0] : -1); end
    tests_run++; if (obs_en[1] !== 1'b1 || obs_busy[2] !== 1'b0) begin tests_failed++; $display("FAIL empty_en_busy: got en %b busy %b expected 1 0", obs_en[1], obs_busy[2]); end
  endtask

  task automatic test_abort();
    bit acc;
    for (int i = 0; i < 3; i++) push_entry(rand_entry(), acc);
    watch(14, 0, 2, 1'b0);
    tests_run++; if (obs_pulse.size() != 2 || obs_done_rel.size() != 0) begin tests_failed++; $display("FAIL abort_counts: got %0d pulses %0d done expected 2 0", obs_pulse.size(), obs_done_rel.size()); end
    for (int i = 0; i < 2 && i < obs_pulse.size(); i++) begin
      tests_run++; if (obs_pulse[i] !== model_q[i]) begin tests_failed++; $display("FAIL abort_pulse%0d: got %0h expected %0h", i, obs_pulse[i], model_q[i]); end
    end
    if (obs_abort_rel > 0) begin
      tests_run++; if (obs_busy[obs_abort_rel + 1] !== 1'b0 || obs_pending[obs_abort_rel + 1] !== 0) begin tests_failed++; $display("FAIL abort_next_cycle: got busy %b pending %0d expected 0 0", obs_busy[obs_abort_rel + 1], obs_pending[obs_abort_rel + 1]); end
    end else begin
      tests_run++; tests_failed++; $display("FAIL abort_not_reached: got %0d pulses expected 2", obs_pulse.size());
    end
    for (int rel = 1; rel <= 14; rel++) begin
      tests_run++; if (obs_en[rel] !== 1'b0) begin tests_failed++; $display("FAIL abort_cms_en_c%0d: got %b expected 0", rel, obs_en[rel]); end
    end
    model_q.delete();
  endtask

  task automatic test_commit_abort_same_cycle();
    bit acc;
    int pulses = 0;
    int dones  = 0;
    int en_high = 0;
    for (int i = 0; i < 2; i++) push_entry(rand_entry(), acc);
    @(negedge clk);
    commit = 1'b1;
    abort  = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    abort  = 1'b0;
    tests_run++; if (pending !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL commit_abort_flush: got pending %0d busy %b expected 0 0", pending, busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pulses += int'(ctrl_write_enable);
      dones  += int'(done);
      en_high += int'(cms_en);
    end
    tests_run++; if (pulses != 0 || dones != 0 || en_high != 0) begin tests_failed++; $display("FAIL commit_abort_quiet: got %0d pulses %0d done %0d en-high expected 0 0 0", pulses, dones, en_high); end
    model_q.delete();
  endtask

  task automatic test_commit_during_gap();
    bit acc;
    for (int i = 0; i < 2; i++) push_entry(rand_entry(), acc);
    watch(16, exp_pulse_rel(0) + 1, 0, 1'b0);
    tests_run++; if (obs_pulse.size() != 2) begin tests_failed++; $display("FAIL gap_commit_pulses: got %0d expected 2", obs_pulse.size()); end
    tests_run++; if (obs_done_rel.size() != 1 || obs_done_rel[0] != exp_done_rel(2)) begin tests_failed++; $display("FAIL gap_commit_done: got %0d pulses first %0d expected 1 at %0d", obs_done_rel.size(), (obs_done_rel.size() > 0) ? obs_done_rel[0] : -1, exp_done_rel(2)); end
    model_q.delete();
  endtask

  task automatic test_random_replays();
    bit acc;
    int n;
    int dr;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push_entry(rand_entry(), acc);
      tests_run++; if (pending !== n) begin tests_failed++; $display("FAIL rand%0d_pending: got %0d expected %0d", it, pending, n); end
      dr = exp_done_rel(n);
      watch(dr + 3, 0, 0, 1'b1);
      tests_run++; if (obs_pulse.size() != n || obs_we_b2b != 0) begin tests_failed++; $display("FAIL rand%0d_pulse_count: got %0d (b2b %0d) expected %0d (b2b 0)", it, obs_pulse.size(), obs_we_b2b, n); end
      for (int i = 0; i < n && i < obs_pulse.size(); i++) begin
        tests_run++; if (obs_pulse[i] !== model_q[i] || obs_pulse_rel[i] != exp_pulse_rel(i)) begin tests_failed++; $display("FAIL rand%0d_pulse%0d: got cycle %0d %0h expected cycle %0d %0h", it, i, obs_pulse_rel[i], obs_pulse[i], exp_pulse_rel(i), model_q[i]); end
      end
      tests_run++; if (obs_done_rel.size() != 1 || obs_done_rel[0] != dr) begin tests_failed++; $display("FAIL rand%0d_done: got %0d pulses first %0d expected 1 at %0d", it, obs_done_rel.size(), (obs_done_rel.size() > 0) ? obs_done_rel[0] : -1, dr); end
      tests_run++; if (obs_en[dr - 1] !== 1'b0 || obs_en[dr] !== 1'b1) begin tests_failed++; $display("FAIL rand%0d_cms_en: got %b%b expected 01", it, obs_en[dr - 1], obs_en[dr]); end
      tests_run++; if (pending !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_end: got pending %0d busy %b expected 0 0", it, pending, busy); end
      model_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_directed_replay();
    test_full_queue();
    test_empty_commit();
    test_abort();
    test_commit_abort_same_cycle();
    test_commit_during_gap();
    test_random_replays();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
